// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern scheduler: off, rotating red ring, breathing green PWM, all-on.
// Everything is held clear while the PLL is unlocked; i_mode is still tracked so the pattern starts clean.
module led_sequencer #(
  parameter int PRESCALE     = 390,
  parameter int PWM_BITS     = 8,
  parameter int STEP_PERIODS = 64,
  parameter int DUTY_STEP    = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_locked,
  input  logic [1:0] i_mode,
  output logic [4:0] o_led,
  output logic       o_step
);

  localparam int PW = $clog2(PRESCALE);
  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
  localparam logic [PW-1:0]       PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_PERIODS - 1);
  localparam logic [PWM_BITS:0]   DSTEP     = (PWM_BITS + 1)'(DUTY_STEP);

  typedef enum logic [1:0] {MODE_OFF, MODE_ROTATE, MODE_BREATHE, MODE_ALL_ON} mode_e;
  typedef enum logic [1:0] {POS_T, POS_R, POS_B, POS_L} pos_e;

  logic [PW-1:0]       pre_q,  pre_d;
  logic [PWM_BITS-1:0] pwm_q,  pwm_d;
  logic [SW-1:0]       stp_q,  stp_d;
  mode_e               mode_q, mode_d;
  pos_e                pos_q,  pos_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                dir_q,  dir_d;   // 0 = rising, 1 = falling
  logic [4:0]          led_q,  led_d;
  logic                step_q, step_d;

  logic                tick, period_end, step, mode_chg;
  logic [PWM_BITS:0]   duty_up, duty_dn;
  logic [4:0]          led_pat;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pre_q  <= '0;
      pwm_q  <= '0;
      stp_q  <= '0;
      mode_q <= MODE_OFF;
      pos_q  <= POS_T;
      duty_q <= '0;
      dir_q  <= 1'b0;
      led_q  <= '0;
      step_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      pwm_q  <= pwm_d;
      stp_q  <= stp_d;
      mode_q <= mode_d;
      pos_q  <= pos_d;
      duty_q <= duty_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      step_q <= step_d;
    end
  end

  // Next state
  always_comb begin
    tick       = (pre_q == PRE_LAST);
    period_end = tick && (pwm_q == MAX);
    step       = period_end && (stp_q == STEP_LAST);
    mode_chg   = (i_mode != mode_q);

    pre_d  = tick ? '0 : pre_q + 1'b1;
    pwm_d  = tick ? pwm_q + 1'b1 : pwm_q;
    stp_d  = period_end ? ((stp_q == STEP_LAST) ? '0 : stp_q + 1'b1) : stp_q;
    mode_d = mode_e'(i_mode);
    pos_d  = pos_q;
    duty_d = duty_q;
    dir_d  = dir_q;
    step_d = step;
    led_d  = led_pat;

    // One extra bit: an underflow shows up in the MSB, an overshoot stays representable
    duty_up = {1'b0, duty_q} + DSTEP;
    duty_dn = {1'b0, duty_q} - DSTEP;

    if (mode_chg) begin
      pos_d  = POS_T;
      duty_d = '0;
      dir_d  = 1'b0;
    end else if (step) begin
      if (mode_q == MODE_ROTATE) begin
        pos_d = pos_e'(pos_q + 2'd1);
      end else if (mode_q == MODE_BREATHE) begin
        if (!dir_q) begin
          if (duty_up >= {1'b0, MAX}) begin
            duty_d = MAX;
            dir_d  = 1'b1;
          end else begin
            duty_d = duty_up[PWM_BITS-1:0];
          end
        end else begin
          if (duty_dn[PWM_BITS] || duty_dn == '0) begin
            duty_d = '0;
            dir_d  = 1'b0;
          end else begin
            duty_d = duty_dn[PWM_BITS-1:0];
          end
        end
      end
    end

    if (!i_locked) begin
      pre_d  = '0;
      pwm_d  = '0;
      stp_d  = '0;
      pos_d  = POS_T;
      duty_d = '0;
      dir_d  = 1'b0;
      led_d  = '0;
      step_d = 1'b0;
    end
  end

  // Output pattern from current state
  always_comb begin
    led_pat = '0;
    case (mode_q)
      MODE_ROTATE:  led_pat = 5'b00001 << pos_q;
      MODE_BREATHE: led_pat = {(pwm_q < duty_q), 4'b0000};
      MODE_ALL_ON:  led_pat = 5'b11111;
      default:      led_pat = '0;
    endcase
  end

  assign o_led  = led_q;
  assign o_step = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - scoreboard bench for led_sequencer against a cycle-count reference model.
module tb_led_sequencer;

  localparam int PRESCALE     = 2;
  localparam int PWM_BITS     = 3;
  localparam int STEP_PERIODS = 2;
  localparam int DUTY_STEP    = 2;
  localparam int MAXV         = (1 << PWM_BITS) - 1;
  localparam int STEP_CLKS    = PRESCALE * (MAXV + 1) * STEP_PERIODS;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic [1:0] mode   = 2'd0;
  logic [4:0] led;
  logic       step;

  led_sequencer #(
    .PRESCALE(PRESCALE), .PWM_BITS(PWM_BITS),
    .STEP_PERIODS(STEP_PERIODS), .DUTY_STEP(DUTY_STEP)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_locked(locked), .i_mode(mode),
    .o_led(led), .o_step(step)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] exp_q[$];

  // Reference state: cycles since counters cleared, registered mode, ring index, duty, direction
  int m_t, m_mode, m_pos, m_duty;
  bit m_up;

  task automatic model_clear();
    m_t = 0; m_mode = 0; m_pos = 0; m_duty = 0; m_up = 1'b1;
  endtask

  always @(posedge rst) model_clear();

  always @(posedge clk) begin : model
    logic [4:0] e_led;
    logic       e_step;
    int         pwm;
    if (rst) begin
      model_clear();
      exp_q.push_back(6'd0);
    end else if (!locked) begin
      model_clear();
      m_mode = int'(mode);
      exp_q.push_back(6'd0);
    end else begin
      pwm    = (m_t / PRESCALE) % (MAXV + 1);
      e_step = ((m_t % STEP_CLKS) == STEP_CLKS - 1);
      case (m_mode)
        1:       e_led = 5'(1 << m_pos);
        2:       e_led = (pwm < m_duty) ? 5'b10000 : 5'b00000;
        3:       e_led = 5'b11111;
        default: e_led = 5'b00000;
      endcase
      if (int'(mode) != m_mode) begin
        m_pos = 0; m_duty = 0; m_up = 1'b1;
      end else if (e_step) begin
        if (m_mode == 1) m_pos = (m_pos + 1) % 4;
        if (m_mode == 2) begin
          if (m_up) begin
            m_duty = (m_duty + DUTY_STEP >= MAXV) ? MAXV : m_duty + DUTY_STEP;
            if (m_duty == MAXV) m_up = 1'b0;
          end else begin
            m_duty = (m_duty - DUTY_STEP <= 0) ? 0 : m_duty - DUTY_STEP;
            if (m_duty == 0) m_up = 1'b1;
          end
        end
      end
      m_mode = int'(mode);
      m_t++;
      exp_q.push_back({e_step, e_led});
    end
  end

  always @(negedge clk) begin : monitor
    logic [5:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({step, led} !== e) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t led=%b step=%b expected led=%b step=%b",
                 $time, led, step, e[4:0], e[5]);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Caller stands just after a negedge; the pulse lands and clears before the next rising edge
  task automatic async_pulse();
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (led !== 5'd0 || step !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset led=%b step=%b expected led=00000 step=0", led, step);
    end
    #1 rst = 1'b0;
  endtask

  initial begin : stim
    int k;
    // Reset then hold unlocked with ROTATE requested
    run(3);
    rst = 1'b0; locked = 1'b0; mode = 2'd1;
    run(100);
    // Rotate through more than a full ring
    locked = 1'b1;
    run(5 * STEP_CLKS + 4);
    // Breathe over a full up/down cycle
    mode = 2'd2;
    run(10 * STEP_CLKS + 4);
    // Mid-pattern mode changes
    mode = 2'd1;
    run(2 * STEP_CLKS + 10);
    mode = 2'd2;
    run(3 * STEP_CLKS);
    mode = 2'd1;
    run(STEP_CLKS + 7);
    // Lock drop in ALL_ON
    mode = 2'd3;
    run(40);
    locked = 1'b0;
    run(5);
    locked = 1'b1;
    run(3 * STEP_CLKS);
    // Async reset while the green LED is lit
    mode = 2'd2;
    run(3 * STEP_CLKS);
    k = 0;
    while (led[4] !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (led[4] !== 1'b1) begin
      n_bad++;
      $display("FAIL wait_green_lit led=%b expected green lit within 200 clocks", led);
    end
    async_pulse();
    run(2 * STEP_CLKS);
    // Randomized mode / lock / reset traffic
    for (int i = 0; i < 60; i++) begin
      mode   = 2'($urandom_range(0, 3));
      locked = ($urandom_range(0, 7) != 0);
      run($urandom_range(1, 80));
      if ($urandom_range(0, 15) == 0) async_pulse();
    end
    run(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
